// File: rtl/payload_frame_ctrl_pkg.sv
// Shared types and frame geometry for the payload framing controller.
package payload_frame_ctrl_pkg;

    localparam int FRAME_SLOTS = 16;
    localparam int WORD_BITS   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

endpackage

// File: rtl/payload_frame_ctrl_frame_slot_counter.sv
// Slot counter for one frame: sync clear, count enable, and two compare outputs
// (programmable header match and last-slot terminal).
module frame_slot_counter
    import payload_frame_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] match_val,
    output logic       match,
    output logic       terminal
);

    logic [3:0] cnt;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            cnt <= 4'd0;
        end else if (en) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign match    = (cnt == match_val);
    assign terminal = (cnt == 4'(FRAME_SLOTS - 1));

endmodule

// File: rtl/payload_frame_ctrl.sv
// Serial frame controller: skips m header slots, packs payload bits into
// 8-bit words (partial word at frame end) and handshakes them to a consumer.
module payload_frame_ctrl
    import payload_frame_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       En,
    input  logic [3:0] m,
    input  logic       word_ack,
    output logic       shifterEn,
    output logic       bit_ready,
    output logic       word_ready,
    output logic [3:0] valid_bits,
    output logic       frame_done,
    output logic       busy
);

    state_t     state, state_nx;
    logic [3:0] m_reg;
    logic [2:0] bit_cnt;
    logic       start_frame, accept, pay_accept;
    logic       hdr_last, slot_last;

    assign start_frame = (state == IDLE) && start;
    assign accept      = En && bit_ready && (state != IDLE);
    assign pay_accept  = accept && (state == PAYLOAD);

    // m_reg is never 0 while in HEADER, so m_reg-1 cannot underflow there.
    frame_slot_counter u_slot_cnt (
        .Clk       (Clk),
        .Reset     (Reset),
        .clr       (start_frame),
        .en        (accept),
        .match_val (4'(m_reg - 4'd1)),
        .match     (hdr_last),
        .terminal  (slot_last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: each always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = (m != 4'd0) ? HEADER : PAYLOAD;
            HEADER:  if (accept && hdr_last) state_nx = PAYLOAD;
            PAYLOAD: if (accept && slot_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The header never stalls; elsewhere an ack frees a slot in the same cycle.
    always_comb begin
        bit_ready = 1'b1;
        if (!Reset && state != HEADER) bit_ready = ~word_ready | word_ack;
        shifterEn = ~Reset & (state == PAYLOAD) & En & bit_ready;
        busy      = (state != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_reg      <= 4'd0;
            bit_cnt    <= 3'd0;
            word_ready <= 1'b0;
            valid_bits <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pay_accept && slot_last;
            if (start_frame) begin
                m_reg   <= m;
                bit_cnt <= 3'd0;
            end
            if (word_ready && word_ack) word_ready <= 1'b0;
            // A completing word overrides the ack clear so back-to-back words stay pending.
            if (pay_accept) begin
                if (bit_cnt == 3'(WORD_BITS - 1)) begin
                    word_ready <= 1'b1;
                    valid_bits <= 4'(WORD_BITS);
                    bit_cnt    <= 3'd0;
                end else if (slot_last) begin
                    word_ready <= 1'b1;
                    valid_bits <= 4'(bit_cnt) + 4'd1;
                    bit_cnt    <= 3'd0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: doc/payload_frame_ctrl.md
PAYLOAD_FRAME_CTRL -- requirements
Module: payload_frame_ctrl

Interface
REQ-001 Clk  input  1  rising-edge clock; the only clock.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  frame-start pulse; sampled only in IDLE.
REQ-004 En  input  1  serial bit slot valid this cycle.
REQ-005 m  input  4  header length in slots (0..15); sampled at start and held internally for the frame.
REQ-006 word_ack  input  1  consumer accepts the pending word.
REQ-007 shifterEn  output  1  shift the payload shift register this cycle.
REQ-008 bit_ready  output  1  controller can accept a slot this cycle.
REQ-009 word_ready  output  1  assembled word pending for the consumer.
REQ-010 valid_bits  output  4  number of valid bits in the pending word (1..8).
REQ-011 frame_done  output  1  one-cycle pulse after the last slot of a frame.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Frame: 16 slots; the first m slots are header (discarded); the remaining 16-m slots are payload.
REQ-014 FSM states: IDLE, HEADER, PAYLOAD.
REQ-015 Accepted slot: En & bit_ready in HEADER or PAYLOAD; slot_cnt (4b) increments per accepted slot.
REQ-016 IDLE: on start, clear slot_cnt and bit_cnt; go to HEADER if m!=0, else go to PAYLOAD.
REQ-017 HEADER: shifterEn=0; on the accepted slot with slot_cnt==m-1, go to PAYLOAD.
REQ-018 PAYLOAD: shifterEn = En & bit_ready; each accepted slot increments bit_cnt (3b, wraps 7->0).
REQ-019 word_ready sets the cycle after the accepted bit that brings the word to 8 bits; valid_bits=8.
REQ-020 Frame end: when the accepted slot has slot_cnt==15, go to IDLE next cycle and pulse frame_done for 1 cycle.
REQ-021 Partial word: if bit_cnt!=0 at frame end, set word_ready with valid_bits=bit_cnt and clear bit_cnt.
REQ-022 word_ready holds, with valid_bits stable, until word_ack; it clears the cycle after the ack.
REQ-023 bit_ready = ~word_ready | word_ack (combinational; ack frees a slot in the same cycle).
REQ-024 In HEADER, bit_ready=1 regardless of word_ready; the header never stalls.
REQ-025 word_ack while word_ready=0 is ignored.
REQ-026 A word completing in the same cycle as an ack of the previous word: word_ready stays 1 and valid_bits updates to the new word.
REQ-027 start outside IDLE is ignored; a new start in IDLE is legal while word_ready is still pending.
REQ-028 En=0 cycles stall all counters; no timeout.

Reset
REQ-029 Reset (any state, mid-frame included): state=IDLE; slot_cnt=0; bit_cnt=0; word_ready=0; valid_bits=0; frame_done=0; shifterEn=0; busy=0.
REQ-030 Reset has priority over start, En and word_ack in the same cycle.
REQ-031 bit_ready=1 while in reset.

Structure
REQ-032 Shared package holds: the state enum typedef, FRAME_SLOTS=16, WORD_BITS=8.
REQ-033 Single sub-module frame_slot_counter: 4-bit counter with sync clear, enable and terminal-match output; used for slot_cnt.
REQ-034 bit_cnt, word_ready and valid_bits are registers in the top-level module.

Verification
REQ-035 m=0, En=1 for 16 cycles, ack immediately -> two words with valid_bits=8; frame_done 1 cycle after slot 15.
REQ-036 m=4, En=1 continuous -> shifterEn low for 4 slots; one word of 8 bits, then a partial word with valid_bits=4; frame_done pulses.
REQ-037 m=0, word_ack withheld 5 cycles after the first word -> bit_ready=0 and shifterEn=0 for 5 cycles; no bits lost; the second word is correct after the ack.
REQ-038 m=15 -> 15 header slots, then 1 payload bit; word_ready with valid_bits=1.
REQ-039 Reset asserted in PAYLOAD at slot 9 with word_ready=1 -> all outputs at reset values next cycle; a later start runs a clean frame.
REQ-040 start pulsed in HEADER and PAYLOAD; ack with word_ready=0 -> no effect on slot_cnt, bit_cnt or word_ready.
